regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 rtl/regfile_mp.sv | 196 +++++++++++++++++++
 tb/tb_regfile_mp.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : regfile_pkg                                               |
// | Brief  : Shared types and helpers for the multi-port register file |
// |          (init/run state encoding, register-count helper).         |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package regfile_pkg;

  // Sequencer state: INIT zero-fills the array, RUN is terminal until reset.
  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Number of architectural registers addressed by a register ID of the given width.
  function automatic int reg_num(input int regid_w);
    return 1 << regid_w;
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : regfile_scoreboard                                        |
// | Brief  : One pending bit per register. Issue marks a destination   |
// |          pending, writeback with clear releases it. Set beats      |
// |          clear when both hit one register in the same cycle.       |
// |          Provides NUM_RD combinational pending lookups, with an    |
// |          optional same-cycle clear bypass.                         |
// | Ports  : clk, rst          clock / async active-high reset         |
// |          iss_en_i/addr_i   qualified issue mark                    |
// |          wr_en_i/addr_i    qualified writeback ports               |
// |          wr_clr_i          writeback also clears pending           |
// |          rd_addr_i         lookup addresses (packed per port)      |
// |          rd_pend_o         pending result per lookup port          |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REGID_W = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iss_en_i,
  input  logic [REGID_W-1:0]        iss_addr_i,
  input  logic [NUM_WR-1:0]         wr_en_i,
  input  logic [NUM_WR*REGID_W-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0]         wr_clr_i,
  input  logic [NUM_RD*REGID_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]         rd_pend_o
);

  localparam int REG_NUM = reg_num(REGID_W);

  logic [REG_NUM-1:0] pend_q;
  logic [REG_NUM-1:0] pend_d;
  logic [NUM_RD-1:0]  w_byp_clr;

  // Clears are applied first so that an issue to the same register wins:
  // the issuing instruction is a new producer the old writeback must not cancel.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j] && wr_clr_i[j]) begin
        pend_d[wr_addr_i[j*REGID_W +: REGID_W]] = 1'b0;
      end
    end
    if (iss_en_i) begin
      pend_d[iss_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Lookup: the highest-index matching writeback decides whether the
  // pending bit is released in the same cycle, mirroring the data bypass.
  always_comb begin
    w_byp_clr = '0;
    rd_pend_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (BYPASS) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en_i[j] &&
              (wr_addr_i[j*REGID_W +: REGID_W] == rd_addr_i[i*REGID_W +: REGID_W])) begin
            w_byp_clr[i] = wr_clr_i[j];
          end
        end
      end
      rd_pend_o[i] = pend_q[rd_addr_i[i*REGID_W +: REGID_W]] & ~w_byp_clr[i];
    end
  end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : regfile_mp                                                |
// | Brief  : Multi-port integer register file with scoreboard.         |
// |          NUM_RD combinational read ports, NUM_WR registered write  |
// |          ports (highest index wins), optional write-to-read        |
// |          bypass, and a post-reset sequencer that zero-fills the    |
// |          array so the storage itself needs no reset.               |
// | Ports  : clk, rst          clock / async active-high reset         |
// |          rs_addr_i         read addresses (packed per port)        |
// |          rs_rdata_o        read data (packed per port)             |
// |          rs_pend_o         source has an outstanding producer      |
// |          wr_en_i/addr_i/data_i  write ports                        |
// |          wr_clr_i          write also clears pending bit           |
// |          iss_en_i/addr_i   mark destination pending                |
// |          ready_o           zero-fill done, array usable            |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REGID_W = 5,
  parameter bit R0_ZERO = 1'b1,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*REGID_W-1:0] rs_addr_i,
  output logic [NUM_RD*XLEN-1:0]    rs_rdata_o,
  output logic [NUM_RD-1:0]         rs_pend_o,
  input  logic [NUM_WR-1:0]         wr_en_i,
  input  logic [NUM_WR*REGID_W-1:0] wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]    wr_data_i,
  input  logic [NUM_WR-1:0]         wr_clr_i,
  input  logic                      iss_en_i,
  input  logic [REGID_W-1:0]        iss_addr_i,
  output logic                      ready_o
);

  localparam int                 REG_NUM    = reg_num(REGID_W);
  localparam logic [REGID_W-1:0] c_CNT_LAST = REGID_W'(REG_NUM - 1);
  localparam logic [REGID_W-1:0] c_CNT_ONE  = REGID_W'(1);

  // ------------------------------------------------------------------
  // Port unpacking
  // ------------------------------------------------------------------
  logic [REGID_W-1:0] w_wr_addr [NUM_WR];
  logic [XLEN-1:0]    w_wr_data [NUM_WR];
  logic [REGID_W-1:0] w_rd_addr [NUM_RD];

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign w_wr_addr[j] = wr_addr_i[j*REGID_W +: REGID_W];
    assign w_wr_data[j] = wr_data_i[j*XLEN +: XLEN];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign w_rd_addr[i] = rs_addr_i[i*REGID_W +: REGID_W];
  end

  // ------------------------------------------------------------------
  // Init sequencer
  // ------------------------------------------------------------------
  rf_state_e          state_q, state_d;
  logic [REGID_W-1:0] init_cnt_q, init_cnt_d;
  logic               w_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RF_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      RF_INIT: begin
        init_cnt_d = init_cnt_q + c_CNT_ONE;
        if (init_cnt_q == c_CNT_LAST) begin
          state_d    = RF_RUN;
          init_cnt_d = '0;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d    = RF_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  assign w_run   = (state_q == RF_RUN);
  assign ready_o = w_run;

  // ------------------------------------------------------------------
  // Write arbitration: during INIT the sequencer owns the array; in RUN
  // later ports overwrite earlier ones, giving highest-index priority.
  // ------------------------------------------------------------------
  logic [REG_NUM-1:0] mem_we_d;
  logic [XLEN-1:0]    mem_d [REG_NUM];
  logic [XLEN-1:0]    mem_q [REG_NUM];

  always_comb begin
    mem_we_d = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      mem_d[r] = '0;
    end
    if (!w_run) begin
      mem_we_d[init_cnt_q] = 1'b1;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && !(R0_ZERO && (w_wr_addr[j] == '0))) begin
          mem_we_d[w_wr_addr[j]] = 1'b1;
          mem_d[w_wr_addr[j]]    = w_wr_data[j];
        end
      end
    end
  end

  // Storage has no reset; the sequencer provides the defined contents.
  always_ff @(posedge clk) begin
    for (int r = 0; r < REG_NUM; r++) begin
      if (mem_we_d[r]) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  // ------------------------------------------------------------------
  // Scoreboard: only qualified (RUN, non-R0) events reach it.
  // ------------------------------------------------------------------
  logic                w_iss_en;
  logic [NUM_WR-1:0]   w_sb_wr_en;
  logic [NUM_RD-1:0]   w_sb_pend;

  assign w_iss_en   = w_run && iss_en_i && !(R0_ZERO && (iss_addr_i == '0));
  assign w_sb_wr_en = wr_en_i & {NUM_WR{w_run}};

  regfile_scoreboard #(
    .REGID_W (REGID_W),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .iss_en_i   (w_iss_en),
    .iss_addr_i (iss_addr_i),
    .wr_en_i    (w_sb_wr_en),
    .wr_addr_i  (wr_addr_i),
    .wr_clr_i   (wr_clr_i),
    .rd_addr_i  (rs_addr_i),
    .rd_pend_o  (w_sb_pend)
  );

  // ------------------------------------------------------------------
  // Read ports with optional bypass. Ascending loop over write ports
  // lets the highest matching index win, same as the array write.
  // ------------------------------------------------------------------
  logic [XLEN-1:0] w_rd_data [NUM_RD];
  logic [NUM_RD-1:0] w_rd_mask;

  always_comb begin
    rs_rdata_o = '0;
    rs_pend_o  = '0;
    w_rd_mask  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_data[i] = mem_q[w_rd_addr[i]];
      if (BYPASS) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en_i[j] && (w_wr_addr[j] == w_rd_addr[i])) begin
            w_rd_data[i] = w_wr_data[j];
          end
        end
      end
      // Outputs are quiet while the array is being zero-filled and for R0.
      w_rd_mask[i] = !w_run || (R0_ZERO && (w_rd_addr[i] == '0));
      if (w_rd_mask[i]) begin
        w_rd_data[i] = '0;
      end
      rs_rdata_o[i*XLEN +: XLEN] = w_rd_data[i];
      rs_pend_o[i]               = w_sb_pend[i] & ~w_rd_mask[i];
    end
  end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_regfile_mp                                             |
// | Brief  : Directed self-checking bench for regfile_mp. Two DUTs     |
// |          share stimulus: u_dut (R0_ZERO=1) and u_dut_nz            |
// |          (R0_ZERO=0). Inputs change on negedge, outputs are        |
// |          sampled between edges.                                    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  pend_a, pend_b;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        ready_a, ready_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk        (clk),
    .rst        (rst),
    .rs_addr_i  (rs_addr),
    .rs_rdata_o (rd_a),
    .rs_pend_o  (pend_a),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_clr_i   (wr_clr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .ready_o    (ready_a)
  );

  regfile_mp #(.R0_ZERO(1'b0)) u_dut_nz (
    .clk        (clk),
    .rst        (rst),
    .rs_addr_i  (rs_addr),
    .rs_rdata_o (rd_b),
    .rs_pend_o  (pend_b),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_clr_i   (wr_clr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .ready_o    (ready_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    wr_clr = 2'b00;
    iss_en = 1'b0;
  endtask

  // Called right after rst is released on a negedge: ready must stay low
  // through 31 edges and rise on the 32nd.
  task automatic check_init(input string pfx);
    #1;
    chk($sformatf("%s_ready_c0", pfx), 32'(ready_a), 32'd0);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_ready_c%0d", pfx, k), 32'(ready_a), (k == 32) ? 32'd1 : 32'd0);
    end
    chk($sformatf("%s_ready_nz", pfx), 32'(ready_b), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rs_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_addr = '0;
    idle();

    // ---------------- Init after reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_init("init");
    for (int r = 0; r < 32; r++) begin
      rs_addr = {5'(31 - r), 5'(r)};
      #1;
      chk($sformatf("zero_p0_r%0d", r), rd_a[31:0], 32'd0);
      chk($sformatf("zero_p1_r%0d", 31 - r), rd_a[63:32], 32'd0);
      chk($sformatf("pend0_r%0d", r), 32'(pend_a), 32'd0);
    end

    // ---------------- Reset mid-init ----------------
    @(negedge clk);
    wr_en   = 2'b11;
    wr_addr = {5'd20, 5'd3};
    wr_data = {32'h0000CAFE, 32'h00000033};
    @(negedge clk);
    idle();
    rs_addr = {5'd20, 5'd3};
    #1;
    chk("pre_rst_r3", rd_a[31:0], 32'h00000033);
    chk("pre_rst_r20", rd_a[63:32], 32'h0000CAFE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midinit_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_init("reinit");
    rs_addr = {5'd20, 5'd3};
    #1;
    chk("post_rst_r3", rd_a[31:0], 32'd0);
    chk("post_rst_r20", rd_a[63:32], 32'd0);

    // ---------------- Dual write, same address ----------------
    @(negedge clk);
    wr_en   = 2'b11;
    wr_addr = {5'd5, 5'd5};
    wr_data = {32'h5555FFFF, 32'hAAAA0000};
    rs_addr = {5'd6, 5'd5};
    #1;
    chk("dual_bypass", rd_a[31:0], 32'h5555FFFF);
    chk("dual_other_reg", rd_a[63:32], 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("dual_stored", rd_a[31:0], 32'h5555FFFF);

    // ---------------- Register 0 ----------------
    @(negedge clk);
    wr_en    = 2'b01;
    wr_addr  = {5'd1, 5'd0};
    wr_data  = {32'h0, 32'hDEADBEEF};
    iss_en   = 1'b1;
    iss_addr = 5'd0;
    rs_addr  = {5'd0, 5'd0};
    #1;
    chk("r0_rd_same", rd_a[31:0], 32'd0);
    chk("r0_pend_same", 32'(pend_a[0]), 32'd0);
    chk("nz_r0_bypass", rd_b[31:0], 32'hDEADBEEF);
    chk("nz_r0_pend_same", 32'(pend_b[0]), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("r0_rd", rd_a[31:0], 32'd0);
    chk("r0_pend", 32'(pend_a[0]), 32'd0);
    chk("nz_r0_rd", rd_b[31:0], 32'hDEADBEEF);
    chk("nz_r0_pend", 32'(pend_b[0]), 32'd1);

    // ---------------- Scoreboard on reg7 ----------------
    @(negedge clk);
    iss_en   = 1'b1;
    iss_addr = 5'd7;
    rs_addr  = {5'd7, 5'd7};
    #1;
    chk("sb_t0_pend", 32'(pend_a[0]), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("sb_t1_pend", 32'(pend_a[0]), 32'd1);
    @(negedge clk);
    iss_en   = 1'b1;    // re-issue of an already pending register
    iss_addr = 5'd7;
    #1;
    chk("sb_t2_pend", 32'(pend_a[1]), 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("sb_t3_pend", 32'(pend_a[0]), 32'd1);
    @(negedge clk);
    wr_en   = 2'b01;
    wr_clr  = 2'b01;
    wr_addr = {5'd1, 5'd7};
    wr_data = {32'h0, 32'h00000012};
    #1;
    chk("sb_t4_pend", 32'(pend_a[0]), 32'd0);
    chk("sb_t4_rd", rd_a[31:0], 32'h00000012);
    @(negedge clk);
    idle();
    #1;
    chk("sb_t5_pend", 32'(pend_a), 32'd0);
    chk("sb_t5_rd", rd_a[63:32], 32'h00000012);

    // ---------------- Set/clear collision on reg9 ----------------
    @(negedge clk);
    iss_en   = 1'b1;
    iss_addr = 5'd9;
    wr_en    = 2'b10;
    wr_clr   = 2'b10;
    wr_addr  = {5'd9, 5'd0};
    wr_data  = {32'h00000099, 32'h0};
    rs_addr  = {5'd8, 5'd9};
    #1;
    chk("coll_same_pend", 32'(pend_a[0]), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("coll_pend", 32'(pend_a[0]), 32'd1);
    chk("coll_rd", rd_a[31:0], 32'h00000099);
    chk("coll_neighbour_pend", 32'(pend_a[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire
